// File: rtl/operand_fetch_pipe.sv
// operand_fetch_pipe: registered operand-fetch stage for the SimpleRisc pipeline.
// Decodes the instruction and reads two operands from an internal register file.
// The register file has a writeback port. The stage also expands the immediate
// and computes the branch target, then presents everything one cycle later
// through a valid/ready output register.
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   in_valid/in_ready         upstream handshake (in_ready is combinational)
//   instr_in, pc_in           instruction word and its PC
//   isSt_in, isRet_in         read-address steering for stores / returns
//   flush_in                  kill in-flight and incoming instruction
//   wb_en/wb_addr/wb_data     register file write port
//   out_valid/out_ready       downstream handshake
//   opcode_out .. pc_out      registered decode results for the held instruction
module operand_fetch_pipe #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 16,
  parameter int PC_W   = 32,
  parameter int RA_IDX = 15,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr_in,
  input  logic [PC_W-1:0] pc_in,
  input  logic            isSt_in,
  input  logic            isRet_in,
  input  logic            flush_in,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      opcode_out,
  output logic            imm_bit_out,
  output logic [AW-1:0]   rd_out,
  output logic [XLEN-1:0] op1_out,
  output logic [XLEN-1:0] op2_out,
  output logic [XLEN-1:0] immx_out,
  output logic [PC_W-1:0] branchTarget_out,
  output logic [PC_W-1:0] pc_out
);

  logic [XLEN-1:0] rf [NREGS];

  logic [AW-1:0]   rd_f, rs1_f, rs2_f, a1, a2, a1_q, a2_q;
  logic [15:0]     imm16;
  logic [1:0]      modifier;
  logic [XLEN-1:0] rd1, rd2, immx;
  logic [PC_W-1:0] btgt;
  logic            accept, hold;

  // Register-address fields are 4 bits wide in the encoding. The size casts
  // truncate or zero-extend them to the register file address width.
  assign rd_f     = AW'(instr_in[25:22]);
  assign rs1_f    = AW'(instr_in[21:18]);
  assign rs2_f    = AW'(instr_in[17:14]);
  assign imm16    = instr_in[15:0];
  assign modifier = instr_in[17:16];

  assign a1 = isRet_in ? AW'(RA_IDX) : rs1_f;
  assign a2 = isSt_in  ? rd_f        : rs2_f;

  // Same-cycle writeback forwarding (compile-time selectable)
  assign rd1 = (BYPASS != 0 && wb_en && wb_addr == a1) ? wb_data : rf[a1];
  assign rd2 = (BYPASS != 0 && wb_en && wb_addr == a2) ? wb_data : rf[a2];

  always_comb begin
    immx = XLEN'($signed(imm16));
    case (modifier)
      2'b01:   immx = XLEN'(imm16);
      2'b10:   immx = XLEN'({imm16, 16'h0000});
      default: immx = XLEN'($signed(imm16));
    endcase
  end

  // The 29-bit signed offset wraps modulo 2^PC_W.
  assign btgt = pc_in + PC_W'($signed({instr_in[26:0], 2'b00}));

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush_in;
  assign hold     = out_valid && !out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wb_en) begin
      rf[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid        <= 1'b0;
      opcode_out       <= '0;
      imm_bit_out      <= 1'b0;
      rd_out           <= '0;
      op1_out          <= '0;
      op2_out          <= '0;
      immx_out         <= '0;
      branchTarget_out <= '0;
      pc_out           <= '0;
      a1_q             <= '0;
      a2_q             <= '0;
    end else if (flush_in) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid        <= 1'b1;
      opcode_out       <= instr_in[31:27];
      imm_bit_out      <= instr_in[26];
      rd_out           <= rd_f;
      op1_out          <= rd1;
      op2_out          <= rd2;
      immx_out         <= immx;
      branchTarget_out <= btgt;
      pc_out           <= pc_in;
      a1_q             <= a1;
      a2_q             <= a2;
    end else if (hold) begin
      // A stalled consumer must never see stale operands. Track writes to
      // the latched read addresses.
      if (wb_en && wb_addr == a1_q) op1_out <= wb_data;
      if (wb_en && wb_addr == a2_q) op2_out <= wb_data;
    end else if (out_valid) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch_pipe.sv
module tb_operand_fetch_pipe;
  localparam int XLEN = 32, PC_W = 32, AW = 4;

  logic            clk = 1'b0;
  logic            rst, in_valid, isSt_in, isRet_in, flush_in, wb_en, out_ready;
  logic [31:0]     instr_in;
  logic [PC_W-1:0] pc_in;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;

  logic            in_ready, out_valid, imm_bit_out;
  logic [4:0]      opcode_out;
  logic [AW-1:0]   rd_out;
  logic [XLEN-1:0] op1_out, op2_out, immx_out;
  logic [PC_W-1:0] branchTarget_out, pc_out;

  logic            nb_in_ready, nb_out_valid, nb_imm_bit;
  logic [4:0]      nb_opcode;
  logic [AW-1:0]   nb_rd;
  logic [XLEN-1:0] nb_op1, nb_op2, nb_immx;
  logic [PC_W-1:0] nb_btgt, nb_pc;

  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  operand_fetch_pipe #(.BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr_in(instr_in), .pc_in(pc_in), .isSt_in(isSt_in), .isRet_in(isRet_in),
    .flush_in(flush_in), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .opcode_out(opcode_out),
    .imm_bit_out(imm_bit_out), .rd_out(rd_out), .op1_out(op1_out),
    .op2_out(op2_out), .immx_out(immx_out), .branchTarget_out(branchTarget_out),
    .pc_out(pc_out));

  operand_fetch_pipe #(.BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nb_in_ready),
    .instr_in(instr_in), .pc_in(pc_in), .isSt_in(isSt_in), .isRet_in(isRet_in),
    .flush_in(flush_in), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(nb_out_valid), .out_ready(out_ready), .opcode_out(nb_opcode),
    .imm_bit_out(nb_imm_bit), .rd_out(nb_rd), .op1_out(nb_op1),
    .op2_out(nb_op2), .immx_out(nb_immx), .branchTarget_out(nb_btgt),
    .pc_out(nb_pc));

  function automatic logic [31:0] mk(input logic [4:0] op, input logic ib,
                                     input logic [3:0] rd, input logic [3:0] rs1,
                                     input logic [17:0] low);
    return {op, ib, rd, rs1, low};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; in_valid = 0; isSt_in = 0; isRet_in = 0; flush_in = 0;
    out_ready = 1; instr_in = '0; pc_in = '0;
    // write during reset must be ignored
    wb_en = 1; wb_addr = 4'd3; wb_data = 32'hDEAD_BEEF;
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_op1", op1_out, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_in_ready", in_ready, 1);

    rst = 0; wb_addr = 4'd3; wb_data = 32'hAA;
    tick();

    // rs1=3, modifier 00, imm16=FFF0 (bits 17:14 = 0011, so rs2 also = r3)
    wb_en = 0; in_valid = 1; pc_in = 32'h100;
    instr_in = mk(5'h01, 1'b0, 4'h0, 4'h3, {2'b00, 16'hFFF0});
    tick();
    chk("b1_valid", out_valid, 1);
    chk("b1_op1", op1_out, 32'hAA);
    chk("b1_op2", op2_out, 32'hAA);
    chk("b1_immx", immx_out, 32'hFFFF_FFF0);
    chk("b1_btgt", branchTarget_out, 32'h0034_00C0);

    // instr[26:0] = 0x7FFFFFE, modifier 11 behaves as sign-extend
    instr_in = mk(5'h0A, 1'b1, 4'hF, 4'hF, 18'h3FFFE);
    tick();
    chk("br_btgt", branchTarget_out, 32'hF8);
    chk("br_immx11", immx_out, 32'hFFFF_FFFE);
    chk("br_opcode", opcode_out, 5'h0A);
    chk("br_immbit", imm_bit_out, 1);
    chk("br_rd", rd_out, 4'hF);

    pc_in = 32'h0;
    instr_in = mk(5'h01, 1'b0, 4'h0, 4'h0, {2'b01, 16'h8001});
    tick();
    chk("imm01", immx_out, 32'h0000_8001);
    instr_in = mk(5'h01, 1'b0, 4'h0, 4'h0, {2'b10, 16'h8001});
    tick();
    chk("imm10", immx_out, 32'h8001_0000);
    chk("b2b_valid", out_valid, 1);

    in_valid = 0; wb_en = 1; wb_addr = 4'd15; wb_data = 32'h1234;
    tick();
    chk("drain_valid", out_valid, 0);
    wb_addr = 4'd7; wb_data = 32'h55;
    tick();

    // return + store steering: A1=r15, A2=rd=r7
    wb_en = 0; in_valid = 1; isRet_in = 1; isSt_in = 1;
    instr_in = mk(5'h02, 1'b0, 4'h7, 4'h5, 18'h08000);
    tick();
    chk("ret_op1", op1_out, 32'h1234);
    chk("st_op2", op2_out, 32'h55);
    isRet_in = 0; isSt_in = 0;

    // same-cycle write/read of r4
    wb_en = 1; wb_addr = 4'd4; wb_data = 32'h99;
    instr_in = mk(5'h01, 1'b0, 4'h0, 4'h4, 18'h0);
    tick();
    chk("byp_op1", op1_out, 32'h99);
    chk("nobyp_op1", nb_op1, 32'h0);

    // stall with op2 sourced from r6
    wb_en = 0; pc_in = 32'h200;
    instr_in = mk(5'h01, 1'b0, 4'h0, 4'h3, {4'h6, 14'h0});
    tick();
    chk("st0_op2", op2_out, 0);
    out_ready = 0; pc_in = 32'h300;
    instr_in = mk(5'h03, 1'b0, 4'h0, 4'h6, 18'h0);
    #1;
    chk("st_in_ready0", in_ready, 0);
    tick();
    chk("st1_pc", pc_out, 32'h200);
    chk("st1_op2", op2_out, 0);
    chk("st1_in_ready", in_ready, 0);
    wb_en = 1; wb_addr = 4'd6; wb_data = 32'h77;
    tick();
    chk("st2_op2", op2_out, 32'h77);
    chk("st2_op1", op1_out, 32'hAA);
    chk("st2_pc", pc_out, 32'h200);
    chk("st2_nb_op2", nb_op2, 32'h77);
    wb_en = 0;
    tick();
    chk("st3_op2", op2_out, 32'h77);
    chk("st3_pc", pc_out, 32'h200);
    chk("st3_valid", out_valid, 1);
    chk("st3_in_ready", in_ready, 0);

    out_ready = 1;
    tick();
    chk("rel1_pc", pc_out, 32'h300);
    chk("rel1_valid", out_valid, 1);
    pc_in = 32'h304;
    tick();
    chk("rel2_pc", pc_out, 32'h304);

    // flush while stalled; the regfile write must still land
    out_ready = 0; pc_in = 32'h308; flush_in = 1;
    wb_en = 1; wb_addr = 4'd8; wb_data = 32'h88;
    tick();
    chk("fl_valid", out_valid, 0);
    flush_in = 0; in_valid = 0; wb_en = 0; out_ready = 1;
    tick();
    chk("fl_dropped", out_valid, 0);
    in_valid = 1; instr_in = mk(5'h01, 1'b0, 4'h0, 4'h8, 18'h0);
    tick();
    chk("fl_wb_op1", op1_out, 32'h88);

    // reset mid-stall
    pc_in = 32'h400; instr_in = mk(5'h01, 1'b0, 4'h0, 4'h0, {4'h6, 14'h0});
    tick();
    chk("r_pre_op2", op2_out, 32'h77);
    out_ready = 0; in_valid = 0;
    tick();
    chk("r_hold_valid", out_valid, 1);
    rst = 1;
    tick();
    chk("r_valid", out_valid, 0);
    chk("r_op1", op1_out, 0);
    chk("r_op2", op2_out, 0);
    chk("r_pc", pc_out, 0);
    chk("r_immx", immx_out, 0);
    chk("r_btgt", branchTarget_out, 0);
    chk("r_opcode", opcode_out, 0);
    rst = 0; out_ready = 1; in_valid = 1;
    instr_in = mk(5'h01, 1'b0, 4'h0, 4'h6, {4'h6, 14'h0});
    tick();
    chk("r6_op1", op1_out, 0);
    chk("r6_op2", op2_out, 0);
    chk("r6_valid", out_valid, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
